vc_traffic_gen: RTL
===================

VC_TRAFFIC_GEN -- requirements
Module: vc_traffic_gen

Interface
REQ-001 SHALL have parameter VC_NUM, default 3, virtual channels per priority.
REQ-002 SHALL have parameter PRIO_NUM, default 2, priority levels; N = VC_NUM*PRIO_NUM channels total.
REQ-003 SHALL have parameter OUTPUT_NUM, default 8, switch outputs; LO = log2 ceiling of OUTPUT_NUM, LV = log2 ceiling of N.
REQ-004 SHALL have parameter MAX_PKT_LEN, default 8, maximum beats per packet (1..16).
REQ-005 SHALL have parameter LFSR_SEED, default 32'hACE1_5EED, nonzero LFSR reset value.
REQ-006 SHALL have clk input 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have reset input 1, synchronous, active-high.
REQ-008 SHALL have enable input 1, permits new requests.
REQ-009 SHALL have load input 8, request threshold per channel per cycle.
REQ-010 SHALL have fixed_vcs_enable input 1, selects deterministic mask mode.
REQ-011 SHALL have fixed_vcs input N, request mask in deterministic mode.
REQ-012 SHALL have same_vc input 1; 1 means output VC equals input VC.
REQ-013 SHALL have selected_vc input LV and cts input 1, the arbiter grant.
REQ-014 SHALL have o_has_packet output N, per-channel request.
REQ-015 SHALL have dest_o output N*LO and output_vc_o output N*LV, flattened per-channel fields, channel i at slice i.
REQ-016 SHALL have beat_valid output 1, last output 1 and xfer_vc output LV.

Function
REQ-017 SHALL run a 32-bit Fibonacci LFSR (taps 32,22,2,1), advancing every non-reset cycle.
REQ-018 SHALL hold one FSM per channel with states IDLE, REQ, XFER.
REQ-019 IDLE->REQ SHALL occur when enable=1 and either fixed_vcs_enable=1 with fixed_vcs[i]=1, or fixed_vcs_enable=0 with (lfsr[7:0] XOR i*8'h25) < load.
REQ-020 On IDLE->REQ SHALL latch the following:
- dest = lfsr[15:8] mod OUTPUT_NUM.
- output VC = i if same_vc=1, else lfsr[23:16] mod N.
- length = 1 + (lfsr[27:24] mod MAX_PKT_LEN).
REQ-021 Latched dest, output VC and length SHALL stay stable from REQ entry until return to IDLE.
REQ-022 o_has_packet[i] SHALL be 1 in REQ and XFER, 0 in IDLE.
REQ-023 REQ->XFER SHALL occur on cts=1 with selected_vc=i while no channel is in XFER.
REQ-024 cts SHALL be ignored when the selected channel is not in REQ, when selected_vc>=N, or while any transfer is active.
REQ-025 In XFER, beat_valid SHALL be 1 every cycle, xfer_vc=i, and a beat counter SHALL count down from the latched length.
REQ-026 last SHALL be 1 on the final beat only; length 1 asserts last on the first XFER cycle.
REQ-027 The cycle after last, the channel SHALL go to IDLE; re-request SHALL occur no earlier than the following cycle.
REQ-028 Deasserting enable SHALL block only IDLE->REQ; channels in REQ or XFER SHALL complete normally.
REQ-029 A fixed_vcs or mode change SHALL affect only channels in IDLE.

Reset
REQ-030 On reset the block SHALL force the following:
- all FSMs to IDLE.
- LFSR to LFSR_SEED.
- counters to 0.
- o_has_packet, dest_o, output_vc_o, beat_valid, last and xfer_vc to 0.
REQ-031 Reset mid-transfer SHALL abort the packet; last SHALL not be asserted for the aborted packet.

Configuration
REQ-032 With VC_TRAFFIC_GEN_STATS_EN defined, the block SHALL add output pkt_count of N*16 bits, one saturating 16-bit count per channel of packets completed (last seen), cleared by reset.
REQ-033 Without VC_TRAFFIC_GEN_STATS_EN, pkt_count and its counters SHALL be absent, and function SHALL otherwise be identical.

Verification
REQ-034 Scenario: reset held for 3 cycles, then released with enable=0 -> all outputs 0 and o_has_packet stays 0 for 100 cycles.
REQ-035 Scenario: fixed_vcs_enable=1, fixed_vcs=6'b000101, enable=1 -> o_has_packet=6'b000101 one cycle later; dest and output VC are stable until grant.
REQ-036 Scenario: same_vc=1, grant channel 2 with cts=1 and selected_vc=2 -> beat_valid runs for the latched length with xfer_vc=2 and output_vc slice 2 = 2; last on the final beat; channel 2 in IDLE the next cycle.
REQ-037 Scenario: MAX_PKT_LEN=1 with back-to-back grants to channels 0 and 3 -> each transfer is one beat with last=1; a cts to channel 3 during channel 0's beat is ignored.
REQ-038 Scenario: load=0 in random mode -> no requests; load=255 -> every IDLE channel requests within 2 cycles.
REQ-039 Scenario: reset asserted on beat 2 of a 5-beat packet -> all outputs 0 next cycle; with STATS_EN, pkt_count does not increment for that packet.

Source files
------------

// File: rtl/vc_traffic_gen.sv
// vc_traffic_gen: LFSR-driven per-channel packet request generator with a single-grant beat engine.
// Define VC_TRAFFIC_GEN_STATS_EN to add pkt_count, a saturating per-channel completed-packet counter.
//   state  | meaning
//   IDLE   | no packet pending, may request when enabled
//   REQ    | packet latched, o_has_packet high, waiting for cts
//   XFER   | sending beats, beat counter runs down from latched length
module vc_traffic_gen #(
  parameter int unsigned VC_NUM      = 3,
  parameter int unsigned PRIO_NUM    = 2,
  parameter int unsigned OUTPUT_NUM  = 8,
  parameter int unsigned MAX_PKT_LEN = 8,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_5EED,
  localparam int unsigned N  = VC_NUM * PRIO_NUM,
  localparam int unsigned LO = (OUTPUT_NUM > 1) ? $clog2(OUTPUT_NUM) : 1,
  localparam int unsigned LV = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [7:0]      load,
  input  logic            fixed_vcs_enable,
  input  logic [N-1:0]    fixed_vcs,
  input  logic            same_vc,
  input  logic [LV-1:0]   selected_vc,
  input  logic            cts,
  output logic [N-1:0]    o_has_packet,
  output logic [N*LO-1:0] dest_o,
  output logic [N*LV-1:0] output_vc_o,
  output logic            beat_valid,
  output logic            last,
  output logic [LV-1:0]   xfer_vc
`ifdef VC_TRAFFIC_GEN_STATS_EN
  ,
  output logic [N*16-1:0] pkt_count
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;

  logic [31:0]   lfsr_q, lfsr_d;
  logic [1:0]    state_q [N];
  logic [1:0]    state_d [N];
  logic [LO-1:0] dest_q  [N];
  logic [LO-1:0] dest_d  [N];
  logic [LV-1:0] ovc_q   [N];
  logic [LV-1:0] ovc_d   [N];
  logic [4:0]    len_q   [N];
  logic [4:0]    len_d   [N];
  logic [4:0]    beat_q, beat_d;

  logic          xfer_any;
  logic [LV-1:0] xfer_idx;
  logic          grant_ok;
  logic [LO-1:0] dest_new;
  logic [LV-1:0] ovc_rand;
  logic [4:0]    len_new;

  assign dest_new = LO'(32'(lfsr_q[15:8]) % OUTPUT_NUM);
  assign ovc_rand = LV'(32'(lfsr_q[23:16]) % N);
  assign len_new  = 5'(32'd1 + (32'(lfsr_q[27:24]) % MAX_PKT_LEN));

  // At most one channel can be in XFER, so a plain scan yields its index.
  always_comb begin
    xfer_any = 1'b0;
    xfer_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (state_q[i] == S_XFER) begin
        xfer_any = 1'b1;
        xfer_idx = LV'(i);
      end
    end
  end

  assign grant_ok = cts && !xfer_any && (32'(selected_vc) < N);

  always_comb begin
    lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    beat_d = beat_q;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      dest_d[i]  = dest_q[i];
      ovc_d[i]   = ovc_q[i];
      len_d[i]   = len_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (enable && (fixed_vcs_enable ? fixed_vcs[i]
                                          : ((lfsr_q[7:0] ^ 8'(i * 37)) < load))) begin
            state_d[i] = S_REQ;
            dest_d[i]  = dest_new;
            ovc_d[i]   = same_vc ? LV'(i) : ovc_rand;
            len_d[i]   = len_new;
          end
        end
        S_REQ: begin
          if (grant_ok && (selected_vc == LV'(i))) begin
            state_d[i] = S_XFER;
            beat_d     = len_q[i];
          end
        end
        S_XFER: begin
          if (beat_q == 5'd1) state_d[i] = S_IDLE;
          beat_d = beat_q - 5'd1;
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
      beat_q <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= S_IDLE;
        dest_q[i]  <= '0;
        ovc_q[i]   <= '0;
        len_q[i]   <= '0;
      end
    end else begin
      lfsr_q <= lfsr_d;
      beat_q <= beat_d;
      for (int i = 0; i < N; i++) begin
        state_q[i] <= state_d[i];
        dest_q[i]  <= dest_d[i];
        ovc_q[i]   <= ovc_d[i];
        len_q[i]   <= len_d[i];
      end
    end
  end

  always_comb begin
    o_has_packet = '0;
    dest_o       = '0;
    output_vc_o  = '0;
    for (int i = 0; i < N; i++) begin
      o_has_packet[i]         = (state_q[i] != S_IDLE);
      dest_o[i*LO +: LO]      = dest_q[i];
      output_vc_o[i*LV +: LV] = ovc_q[i];
    end
  end

  assign beat_valid = xfer_any;
  assign xfer_vc    = xfer_idx;
  assign last       = xfer_any && (beat_q == 5'd1);

`ifdef VC_TRAFFIC_GEN_STATS_EN
  logic [15:0] cnt_q [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (last && (xfer_idx == LV'(i)) && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < N; i++) pkt_count[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule
